// File: rtl/sgr_param_sequencer.sv
// sgr_param_sequencer
//   Collects the parameter characters of one CSI SGR sequence (after "ESC ["
//   has been stripped). It replays them as a paced command stream for the
//   graphics-attribute block: INIT, EMIT..., FINAL. When there are no
//   parameters it issues a single FINAL_DEFAULT instead.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   start_i       one-cycle pulse: CSI introducer seen, (re)starts collection
//   in_valid_i    in_char_i valid
//   in_ready_o    character accepted when in_valid_i && in_ready_o
//   in_char_i     ASCII parameter or final character
//   cmd_valid_o   one-cycle command strobe (no backpressure)
//   cmd_type_o    0=INIT 1=EMIT 2=FINAL 3=FINAL_DEFAULT (held between strobes)
//   cmd_pn_o      parameter value (held between strobes)
//   busy_o        high whenever the sequencer is not idle
//   overflow_o    sticky: more than MAX_PARAMS fields seen, cleared by start_i
//   abort_o       one-cycle pulse when a sequence is discarded
module sgr_param_sequencer #(
  parameter int MAX_PARAMS = 16,
  parameter int GAP        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_char_i,
  output logic       cmd_valid_o,
  output logic [1:0] cmd_type_o,
  output logic [7:0] cmd_pn_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic       abort_o
);

  localparam int CNT_W = $clog2(MAX_PARAMS + 1);
  localparam int IDX_W = $clog2(MAX_PARAMS);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PARAMS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       GAP_LOAD = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

  localparam logic [1:0] CMD_INIT  = 2'd0;
  localparam logic [1:0] CMD_EMIT  = 2'd1;
  localparam logic [1:0] CMD_FINAL = 2'd2;
  localparam logic [1:0] CMD_FDEF  = 2'd3;

  localparam logic [7:0] CH_SEMI = 8'h3B;
  localparam logic [7:0] CH_M    = 8'h6D;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ISSUE, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic             seen_q, seen_d;
  logic             ovf_q, ovf_d;
  logic             abort_q, abort_d;
  logic             last_q, last_d;
  logic [2:0]       gap_q, gap_d;
  logic [1:0]       type_q, type_d;
  logic [7:0]       pn_q, pn_d;
  logic [7:0]       pbuf_q [MAX_PARAMS];

  logic             commit;
  logic             wr_en;
  logic             cmd_valid;
  logic [1:0]       cur_type;
  logic [7:0]       cur_pn;
  logic             is_last;
  logic             is_digit;
  logic [IDX_W-1:0] rd_idx;

  // Decimal accumulate with saturation; 12 bits hold 255*10+9 without wrap.
  function automatic logic [7:0] sat_acc(input logic [7:0] acc, input logic [3:0] d);
    logic [11:0] w;
    w = ({4'd0, acc} * 12'd10) + {8'd0, d};
    return (w > 12'd255) ? 8'd255 : w[7:0];
  endfunction

  assign is_digit = (in_char_i >= 8'h30) && (in_char_i <= 8'h39);
  // Command k (k>=1) carries field k-1; modular subtraction in IDX_W bits is exact.
  assign rd_idx   = idx_q[IDX_W-1:0] - IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    seen_d    = seen_q;
    ovf_d     = ovf_q;
    abort_d   = 1'b0;
    last_d    = last_q;
    gap_d     = gap_q;
    type_d    = type_q;
    pn_d      = pn_q;
    commit    = 1'b0;
    wr_en     = 1'b0;
    cmd_valid = 1'b0;
    cur_type  = type_q;
    cur_pn    = pn_q;
    is_last   = last_q;

    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (start_i) begin
          state_d = S_COLLECT;
          count_d = '0;
          acc_d   = '0;
          seen_d  = 1'b0;
          ovf_d   = 1'b0;
        end else if (state_q == S_COLLECT && in_valid_i) begin
          if (is_digit) begin
            acc_d  = sat_acc(acc_q, in_char_i[3:0]);
            seen_d = 1'b1;
          end else if (in_char_i == CH_SEMI) begin
            commit = 1'b1;
            acc_d  = '0;
            seen_d = 1'b1;
          end else if (in_char_i == CH_M) begin
            // A trailing ';' leaves seen set, so "5;m" yields 5,0.
            commit  = seen_q;
            idx_d   = '0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
            abort_d = 1'b1;
            count_d = '0;
            acc_d   = '0;
            seen_d  = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        cmd_valid = 1'b1;
        if (count_q == '0) begin
          cur_type = CMD_FDEF;
          cur_pn   = 8'd0;
          is_last  = 1'b1;
        end else if (idx_q == '0) begin
          cur_type = CMD_INIT;
          cur_pn   = 8'd0;
          is_last  = 1'b0;
        end else begin
          is_last  = (idx_q == count_q);
          cur_type = is_last ? CMD_FINAL : CMD_EMIT;
          cur_pn   = pbuf_q[rd_idx];
        end
        type_d = cur_type;
        pn_d   = cur_pn;
        last_d = is_last;
        idx_d  = idx_q + CNT_ONE;
        if (GAP == 0) begin
          state_d = is_last ? S_IDLE : S_ISSUE;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q == 3'd0) state_d = last_q ? S_IDLE : S_ISSUE;
        else               gap_d   = gap_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // A full buffer drops the field but keeps what is already stored.
    if (commit) begin
      if (count_q == MAX_CNT) begin
        ovf_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        count_d = count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      seen_q  <= 1'b0;
      ovf_q   <= 1'b0;
      abort_q <= 1'b0;
      last_q  <= 1'b0;
      gap_q   <= 3'd0;
      type_q  <= 2'd0;
      pn_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      seen_q  <= seen_d;
      ovf_q   <= ovf_d;
      abort_q <= abort_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      type_q  <= type_d;
      pn_q    <= pn_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pbuf_q[count_q[IDX_W-1:0]] <= acc_q;
  end

  assign in_ready_o  = (state_q == S_IDLE) || (state_q == S_COLLECT);
  assign busy_o      = (state_q != S_IDLE);
  assign cmd_valid_o = cmd_valid;
  assign cmd_type_o  = cur_type;
  assign cmd_pn_o    = cur_pn;
  assign overflow_o  = ovf_q;
  assign abort_o     = abort_q;

endmodule

// File: tb/tb_sgr_param_sequencer.sv
// Bench for sgr_param_sequencer. Three instances cover the parameter corners:
//   0: MAX_PARAMS=16 GAP=1   1: MAX_PARAMS=2 GAP=1   2: MAX_PARAMS=16 GAP=0
module tb_sgr_param_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_char;
  int         sel;

  logic [2:0] st, iv, rdy, cv, bsy, ovf, ab;
  logic [1:0] ty [3];
  logic [7:0] pn [3];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int sel;
    int cyc;
    int t;
    int pn;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int              sel;
    string           s;
    int              n;
    logic            ovf;
    logic            ab;
    logic [5:0][7:0] pn;
  } vec_t;
  vec_t vecs[$];

  for (genvar d = 0; d < 3; d++) begin : g_gate
    assign st[d] = start && (sel == d);
    assign iv[d] = in_valid && (sel == d);
  end

  sgr_param_sequencer #(.MAX_PARAMS(16), .GAP(1)) dut_a (
    .clk(clk), .rst(rst), .start_i(st[0]), .in_valid_i(iv[0]), .in_ready_o(rdy[0]),
    .in_char_i(in_char), .cmd_valid_o(cv[0]), .cmd_type_o(ty[0]), .cmd_pn_o(pn[0]),
    .busy_o(bsy[0]), .overflow_o(ovf[0]), .abort_o(ab[0]));

  sgr_param_sequencer #(.MAX_PARAMS(2), .GAP(1)) dut_b (
    .clk(clk), .rst(rst), .start_i(st[1]), .in_valid_i(iv[1]), .in_ready_o(rdy[1]),
    .in_char_i(in_char), .cmd_valid_o(cv[1]), .cmd_type_o(ty[1]), .cmd_pn_o(pn[1]),
    .busy_o(bsy[1]), .overflow_o(ovf[1]), .abort_o(ab[1]));

  sgr_param_sequencer #(.MAX_PARAMS(16), .GAP(0)) dut_c (
    .clk(clk), .rst(rst), .start_i(st[2]), .in_valid_i(iv[2]), .in_ready_o(rdy[2]),
    .in_char_i(in_char), .cmd_valid_o(cv[2]), .cmd_type_o(ty[2]), .cmd_pn_o(pn[2]),
    .busy_o(bsy[2]), .overflow_o(ovf[2]), .abort_o(ab[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe on any instance must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (cv[d]) begin
        total++;
        if (sbq.size() == 0 || sbq[0].sel != d) begin
          bad++;
          $display("FAIL unexpected_cmd dut=%0d cyc=%0d type=%0d pn=%0d", d, cyc, ty[d], pn[d]);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (int'(ty[d]) != e.t || int'(pn[d]) != e.pn || cyc != e.cyc) begin
            bad++;
            $display("FAIL cmd dut=%0d got type=%0d pn=%0d cyc=%0d want type=%0d pn=%0d cyc=%0d",
                     d, ty[d], pn[d], cyc, e.t, e.pn, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic add(input int s_sel, input string s, input int n, input logic o, input logic a,
                     input int p0 = 0, input int p1 = 0, input int p2 = 0,
                     input int p3 = 0, input int p4 = 0, input int p5 = 0);
    vec_t v;
    v.sel = s_sel; v.s = s; v.n = n; v.ovf = o; v.ab = a;
    v.pn[0] = p0[7:0]; v.pn[1] = p1[7:0]; v.pn[2] = p2[7:0];
    v.pn[3] = p3[7:0]; v.pn[4] = p4[7:0]; v.pn[5] = p5[7:0];
    vecs.push_back(v);
  endtask

  // pre, when non-empty, is sent after a first start; the second start then
  // arrives together with a valid '9' that must be ignored.
  task automatic run_vec(input vec_t v, input string pre);
    int g, t_m, got, exp_rdy;
    g = (v.sel == 2) ? 0 : 1;
    t_m = 0;
    sel = v.sel;
    @(posedge clk); #1;
    if (pre.len() > 0) begin
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < pre.len(); i++) begin
        in_valid = 1'b1; in_char = pre[i]; @(posedge clk); #1;
      end
    end
    start = 1'b1; in_valid = (pre.len() > 0); in_char = 8'h39;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < v.s.len(); i++) begin
      in_valid = 1'b1; in_char = v.s[i]; t_m = cyc;
      if (i == v.s.len() - 1) begin
        for (int k = 0; k < v.n; k++) begin
          exp_t e;
          e.sel = v.sel;
          e.cyc = t_m + 1 + k * (g + 1);
          e.t   = (v.n == 1) ? 3 : (k == 0) ? 0 : (k == v.n - 1) ? 2 : 1;
          e.pn  = int'(v.pn[k]);
          sbq.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("abort_pulse[%s]", v.s), int'(ab[v.sel]), int'(v.ab));
    got = -1;
    for (int i = 0; i < 200; i++) begin
      if (rdy[v.sel]) begin got = cyc; break; end
      @(negedge clk);
    end
    exp_rdy = v.ab ? t_m + 1 : t_m + 1 + v.n * (g + 1);
    chk($sformatf("ready_cycle[%s]", v.s), got - t_m, exp_rdy - t_m);
    chk($sformatf("busy_low[%s]", v.s), int'(bsy[v.sel]), 0);
    chk($sformatf("overflow[%s]", v.s), int'(ovf[v.sel]), int'(v.ovf));
    chk($sformatf("drained[%s]", v.s), sbq.size(), 0);
    if (v.ab) begin
      @(negedge clk);
      chk("abort_one_cycle", int'(ab[v.sel]), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_char = 8'h00; sel = 0;

    add(0, "31;1m",         3, 1'b0, 1'b0, 0, 31, 1);
    add(0, "m",             1, 1'b0, 1'b0, 0);
    add(0, "38;2;300;;7m",  6, 1'b0, 1'b0, 0, 38, 2, 255, 0, 7);
    add(1, "1;2;3m",        3, 1'b1, 1'b0, 0, 1, 2);
    add(1, "9m",            2, 1'b0, 1'b0, 0, 9);
    add(0, "4;x",           0, 1'b0, 1'b1);
    add(0, "7m",            2, 1'b0, 1'b0, 0, 7);
    add(0, "5;m",           3, 1'b0, 1'b0, 0, 5, 0);
    add(0, ";m",            3, 1'b0, 1'b0, 0, 0, 0);
    add(0, "999m",          2, 1'b0, 1'b0, 0, 255);
    add(2, "12;3m",         3, 1'b0, 1'b0, 0, 12, 3);
    add(2, "m",             1, 1'b0, 1'b0, 0);

    #2;
    chk("rst_cmd_valid", int'(cv[0]), 0);
    chk("rst_cmd_type",  int'(ty[0]), 0);
    chk("rst_cmd_pn",    int'(pn[0]), 0);
    chk("rst_busy",      int'(bsy[0]), 0);
    chk("rst_overflow",  int'(ovf[0]), 0);
    chk("rst_abort",     int'(ab[0]), 0);
    chk("rst_in_ready",  int'(rdy[0]), 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], "");

    // Restart mid-collection with a same-cycle character: buffer is cleared.
    add(0, "7m", 2, 1'b0, 1'b0, 0, 7);
    run_vec(vecs[vecs.size() - 1], "5;");

    // Reset during the EMIT strobe of a GAP=0 drain.
    begin
      int t_m;
      exp_t e;
      sel = 2;
      @(posedge clk); #1;
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      v.s = "1;2m";
      t_m = 0;
      for (int i = 0; i < v.s.len(); i++) begin
        in_valid = 1'b1; in_char = v.s[i]; t_m = cyc;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      e.sel = 2; e.cyc = t_m + 1; e.t = 0; e.pn = 0; sbq.push_back(e);
      e.sel = 2; e.cyc = t_m + 2; e.t = 1; e.pn = 1; sbq.push_back(e);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 chk("rst_drops_cmd_valid", int'(cv[2]), 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("no_cmd_after_rst", sbq.size(), 0);
      chk("rdy_after_rst", int'(rdy[2]), 1);
      chk("busy_after_rst", int'(bsy[2]), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
